// File: rtl/axi_lite_master_pkg.sv
// Shared AXI-Lite definitions: response codes and the master's state encoding.
package axi_lite_master_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ
    } master_state_t;

endpackage

// File: rtl/axi_lite_master.sv
// AXI-Lite initiator: turns a single req/ready user request into one AXI-Lite
// read or write transaction, reporting read data and response with a done pulse.
module axi_lite_master #(
    parameter int AXI_ADDR_WIDTH = 20,
    parameter int AXI_DATA_WIDTH = 16
) (
    input  logic                              clk,
    input  logic                              reset,

    input  logic                              req,
    input  logic                              write_enable,
    input  logic [AXI_ADDR_WIDTH-1:0]         addr,
    input  logic [AXI_DATA_WIDTH-1:0]         write_data,
    input  logic [(AXI_DATA_WIDTH+7)/8-1:0]   write_strb,
    output logic                              ready,
    output logic                              done,
    output logic [AXI_DATA_WIDTH-1:0]         read_data,
    output logic [1:0]                        resp,

    output logic [AXI_ADDR_WIDTH-1:0]         m_axi_awaddr,
    output logic                              m_axi_awvalid,
    input  logic                              m_axi_awready,

    output logic [AXI_DATA_WIDTH-1:0]         m_axi_wdata,
    output logic [(AXI_DATA_WIDTH+7)/8-1:0]   m_axi_wstrb,
    output logic                              m_axi_wvalid,
    input  logic                              m_axi_wready,

    input  logic [1:0]                        m_axi_bresp,
    input  logic                              m_axi_bvalid,
    output logic                              m_axi_bready,

    output logic [AXI_ADDR_WIDTH-1:0]         m_axi_araddr,
    output logic                              m_axi_arvalid,
    input  logic                              m_axi_arready,

    input  logic [AXI_DATA_WIDTH-1:0]         m_axi_rdata,
    input  logic [1:0]                        m_axi_rresp,
    input  logic                              m_axi_rvalid,
    output logic                              m_axi_rready
);

    import axi_lite_master_pkg::*;

    master_state_t state;
    logic          aw_done;
    logic          w_done;

    always_ff @(posedge clk) begin
        done <= 1'b0;
        if (reset) begin
            state         <= ST_IDLE;
            ready         <= 1'b1;
            read_data     <= '0;
            resp          <= RESP_OKAY;
            m_axi_awaddr  <= '0;
            m_axi_awvalid <= 1'b0;
            m_axi_wdata   <= '0;
            m_axi_wstrb   <= '0;
            m_axi_wvalid  <= 1'b0;
            m_axi_bready  <= 1'b0;
            m_axi_araddr  <= '0;
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b0;
            aw_done       <= 1'b0;
            w_done        <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    ready <= 1'b1;
                    if (req) begin
                        ready <= 1'b0;
                        if (write_enable) begin
                            state         <= ST_WRITE;
                            m_axi_awaddr  <= addr;
                            m_axi_wdata   <= write_data;
                            m_axi_wstrb   <= write_strb;
                            m_axi_awvalid <= 1'b1;
                            m_axi_wvalid  <= 1'b1;
                            m_axi_bready  <= 1'b1;
                            aw_done       <= 1'b0;
                            w_done        <= 1'b0;
                        end else begin
                            state         <= ST_READ;
                            m_axi_araddr  <= addr;
                            m_axi_arvalid <= 1'b1;
                            m_axi_rready  <= 1'b1;
                        end
                    end
                end

                ST_WRITE: begin
                    if (!aw_done && m_axi_awvalid && m_axi_awready) begin
                        m_axi_awvalid <= 1'b0;
                        aw_done       <= 1'b1;
                    end
                    if (!w_done && m_axi_wvalid && m_axi_wready) begin
                        m_axi_wvalid <= 1'b0;
                        w_done       <= 1'b1;
                    end
                    // B completes the write even if it lands with the last AW/W handshake
                    if (m_axi_bready && m_axi_bvalid) begin
                        resp          <= m_axi_bresp;
                        m_axi_bready  <= 1'b0;
                        m_axi_awvalid <= 1'b0;
                        m_axi_wvalid  <= 1'b0;
                        done          <= 1'b1;
                        ready         <= 1'b1;
                        state         <= ST_IDLE;
                    end
                end

                ST_READ: begin
                    if (m_axi_arvalid && m_axi_arready) begin
                        m_axi_arvalid <= 1'b0;
                    end
                    if (m_axi_rready && m_axi_rvalid) begin
                        read_data     <= m_axi_rdata;
                        resp          <= m_axi_rresp;
                        m_axi_rready  <= 1'b0;
                        m_axi_arvalid <= 1'b0;
                        done          <= 1'b1;
                        ready         <= 1'b1;
                        state         <= ST_IDLE;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                    ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_lite_master.sv
// Directed bench for axi_lite_master: zero-wait vector table plus stalled,
// skewed, busy and reset sequences.
module tb_axi_lite_master;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic        write_enable;
    logic [19:0] addr;
    logic [15:0] write_data;
    logic [1:0]  write_strb;
    logic        ready;
    logic        done;
    logic [15:0] read_data;
    logic [1:0]  resp;
    logic [19:0] m_axi_awaddr;
    logic        m_axi_awvalid;
    logic        m_axi_awready;
    logic [15:0] m_axi_wdata;
    logic [1:0]  m_axi_wstrb;
    logic        m_axi_wvalid;
    logic        m_axi_wready;
    logic [1:0]  m_axi_bresp;
    logic        m_axi_bvalid;
    logic        m_axi_bready;
    logic [19:0] m_axi_araddr;
    logic        m_axi_arvalid;
    logic        m_axi_arready;
    logic [15:0] m_axi_rdata;
    logic [1:0]  m_axi_rresp;
    logic        m_axi_rvalid;
    logic        m_axi_rready;

    int checks = 0;
    int errors = 0;

    axi_lite_master #(
        .AXI_ADDR_WIDTH(20),
        .AXI_DATA_WIDTH(16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .write_enable (write_enable),
        .addr         (addr),
        .write_data   (write_data),
        .write_strb   (write_strb),
        .ready        (ready),
        .done         (done),
        .read_data    (read_data),
        .resp         (resp),
        .m_axi_awaddr (m_axi_awaddr),
        .m_axi_awvalid(m_axi_awvalid),
        .m_axi_awready(m_axi_awready),
        .m_axi_wdata  (m_axi_wdata),
        .m_axi_wstrb  (m_axi_wstrb),
        .m_axi_wvalid (m_axi_wvalid),
        .m_axi_wready (m_axi_wready),
        .m_axi_bresp  (m_axi_bresp),
        .m_axi_bvalid (m_axi_bvalid),
        .m_axi_bready (m_axi_bready),
        .m_axi_araddr (m_axi_araddr),
        .m_axi_arvalid(m_axi_arvalid),
        .m_axi_arready(m_axi_arready),
        .m_axi_rdata  (m_axi_rdata),
        .m_axi_rresp  (m_axi_rresp),
        .m_axi_rvalid (m_axi_rvalid),
        .m_axi_rready (m_axi_rready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [19:0] addr;
        logic [15:0] wdata;
        logic [1:0]  strb;
        logic [15:0] slv_rdata;
        logic [1:0]  slv_resp;
        logic [15:0] exp_rdata;
        logic [1:0]  exp_resp;
    } vec_t;

    vec_t vecs[6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic slave_idle();
        m_axi_awready = 1'b0;
        m_axi_wready  = 1'b0;
        m_axi_arready = 1'b0;
        m_axi_bvalid  = 1'b0;
        m_axi_rvalid  = 1'b0;
        m_axi_bresp   = 2'b00;
        m_axi_rresp   = 2'b00;
        m_axi_rdata   = 16'h0000;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int dones;

        //                we    addr      wdata     strb   slv_rdata slv_resp exp_rdata exp_resp
        vecs[0] = '{1'b1, 20'h00012, 16'hBEEF, 2'b11, 16'h0000, 2'b00, 16'h0000, 2'b00};
        vecs[1] = '{1'b0, 20'h00012, 16'h0000, 2'b00, 16'hBEEF, 2'b00, 16'hBEEF, 2'b00};
        vecs[2] = '{1'b1, 20'h3FFFF, 16'h0000, 2'b01, 16'h7777, 2'b10, 16'hBEEF, 2'b10};
        vecs[3] = '{1'b0, 20'hFFFFF, 16'h0000, 2'b00, 16'hA5A5, 2'b11, 16'hA5A5, 2'b11};
        vecs[4] = '{1'b1, 20'h00000, 16'hFFFF, 2'b10, 16'h5555, 2'b01, 16'hA5A5, 2'b01};
        vecs[5] = '{1'b0, 20'h00001, 16'h0000, 2'b00, 16'h0001, 2'b00, 16'h0001, 2'b00};

        reset = 1'b1;
        req = 1'b0;
        write_enable = 1'b0;
        addr = '0;
        write_data = '0;
        write_strb = '0;
        slave_idle();
        tick();
        tick();
        check("rst_ready",     32'(ready), 32'd1);
        check("rst_done",      32'(done), 32'd0);
        check("rst_valids",    32'({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready}), 32'd0);
        check("rst_read_data", 32'(read_data), 32'd0);
        check("rst_resp",      32'(resp), 32'd0);
        check("rst_awaddr",    32'(m_axi_awaddr), 32'd0);
        reset = 1'b0;
        tick();

        // Zero-wait slave: every ready/valid high, back-to-back requests
        m_axi_awready = 1'b1;
        m_axi_wready  = 1'b1;
        m_axi_arready = 1'b1;
        m_axi_bvalid  = 1'b1;
        m_axi_rvalid  = 1'b1;
        for (int i = 0; i < 6; i++) begin
            req          = 1'b1;
            write_enable = vecs[i].we;
            addr         = vecs[i].addr;
            write_data   = vecs[i].wdata;
            write_strb   = vecs[i].strb;
            m_axi_bresp  = vecs[i].slv_resp;
            m_axi_rresp  = vecs[i].slv_resp;
            m_axi_rdata  = vecs[i].slv_rdata;
            tick();
            req = 1'b0;
            check("n1_awvalid", 32'(m_axi_awvalid), 32'(vecs[i].we));
            check("n1_wvalid",  32'(m_axi_wvalid),  32'(vecs[i].we));
            check("n1_bready",  32'(m_axi_bready),  32'(vecs[i].we));
            check("n1_arvalid", 32'(m_axi_arvalid), 32'(!vecs[i].we));
            check("n1_rready",  32'(m_axi_rready),  32'(!vecs[i].we));
            check("n1_ready",   32'(ready), 32'd0);
            check("n1_done",    32'(done), 32'd0);
            if (vecs[i].we) begin
                check("n1_awaddr", 32'(m_axi_awaddr), 32'(vecs[i].addr));
                check("n1_wdata",  32'(m_axi_wdata),  32'(vecs[i].wdata));
                check("n1_wstrb",  32'(m_axi_wstrb),  32'(vecs[i].strb));
            end else begin
                check("n1_araddr", 32'(m_axi_araddr), 32'(vecs[i].addr));
            end
            tick();
            check("n2_done",      32'(done), 32'd1);
            check("n2_ready",     32'(ready), 32'd1);
            check("n2_resp",      32'(resp), 32'(vecs[i].exp_resp));
            check("n2_read_data", 32'(read_data), 32'(vecs[i].exp_rdata));
            check("n2_valids",    32'({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready}), 32'd0);
        end
        tick();
        check("b2b_done_low", 32'(done), 32'd0);

        // Skewed write: W at N+1, AW at N+4, B at N+6
        slave_idle();
        req = 1'b1; write_enable = 1'b1; addr = 20'h0ABCD; write_data = 16'h1357; write_strb = 2'b10;
        dones = 0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            req = 1'b0;
            m_axi_wready  = (k == 1);
            m_axi_awready = (k == 4);
            m_axi_bvalid  = (k == 6);
            m_axi_bresp   = 2'b01;
            if (done) dones++;
            if (k == 1) check("sw_wvalid_n1", 32'(m_axi_wvalid), 32'd1);
            if (k >= 1 && k <= 4) begin
                check("sw_awvalid_hold", 32'(m_axi_awvalid), 32'd1);
                check("sw_awaddr_hold",  32'(m_axi_awaddr), 32'h0ABCD);
            end
            if (k == 2) check("sw_wvalid_drop", 32'(m_axi_wvalid), 32'd0);
            if (k == 5) begin
                check("sw_awvalid_drop", 32'(m_axi_awvalid), 32'd0);
                check("sw_bready",       32'(m_axi_bready), 32'd1);
                check("sw_ready_busy",   32'(ready), 32'd0);
            end
            if (k == 6) check("sw_done_early", 32'(done), 32'd0);
            if (k == 7) begin
                check("sw_done",      32'(done), 32'd1);
                check("sw_resp",      32'(resp), 32'd1);
                check("sw_read_data", 32'(read_data), 32'h0001);
                check("sw_ready",     32'(ready), 32'd1);
            end
        end
        check("sw_done_count", 32'(dones), 32'd1);

        // Stalled read: AR at N+3, rvalid N+4..N+8 with SLVERR
        slave_idle();
        req = 1'b1; write_enable = 1'b0; addr = 20'h54321;
        dones = 0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            req = 1'b0;
            m_axi_arready = (k == 3);
            m_axi_rvalid  = (k >= 4 && k <= 8);
            m_axi_rdata   = 16'h1234;
            m_axi_rresp   = 2'b10;
            if (done) dones++;
            if (k <= 3) begin
                check("sr_arvalid_hold", 32'(m_axi_arvalid), 32'd1);
                check("sr_araddr_hold",  32'(m_axi_araddr), 32'h54321);
                check("sr_rready",       32'(m_axi_rready), 32'd1);
            end
            if (k == 4) begin
                check("sr_arvalid_drop", 32'(m_axi_arvalid), 32'd0);
                check("sr_done_early",   32'(done), 32'd0);
            end
            if (k == 5) begin
                check("sr_done",      32'(done), 32'd1);
                check("sr_resp",      32'(resp), 32'd2);
                check("sr_read_data", 32'(read_data), 32'h1234);
            end
        end
        check("sr_done_count", 32'(dones), 32'd1);
        check("sr_rready_idle", 32'(m_axi_rready), 32'd0);

        // Busy request while a write is in flight is dropped
        slave_idle();
        req = 1'b1; write_enable = 1'b1; addr = 20'h11111; write_data = 16'h2222; write_strb = 2'b11;
        dones = 0;
        for (int k = 1; k <= 7; k++) begin
            tick();
            req           = (k == 1);
            write_enable  = 1'b0;
            addr          = 20'h99999;
            m_axi_awready = (k == 2);
            m_axi_wready  = (k == 2);
            m_axi_bvalid  = (k == 2);
            if (done) dones++;
            if (k == 1) check("busy_ready", 32'(ready), 32'd0);
            if (k == 2) begin
                check("busy_awaddr",  32'(m_axi_awaddr), 32'h11111);
                check("busy_arvalid", 32'(m_axi_arvalid), 32'd0);
            end
        end
        check("busy_done_count", 32'(dones), 32'd1);
        check("busy_no_queue",   32'({m_axi_awvalid, m_axi_arvalid, ready}), 32'd1);
        check("busy_read_data",  32'(read_data), 32'h1234);

        // Reset in the middle of a stalled write, then stray bvalid in IDLE
        slave_idle();
        req = 1'b1; write_enable = 1'b1; addr = 20'h0F0F0; write_data = 16'hCAFE; write_strb = 2'b11;
        dones = 0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            req          = 1'b0;
            reset        = (k == 2);
            m_axi_bvalid = (k >= 3 && k <= 5);
            if (done) dones++;
            if (k == 1) check("rw_awvalid", 32'(m_axi_awvalid), 32'd1);
            if (k == 3) begin
                check("rw_valids",    32'({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready}), 32'd0);
                check("rw_ready",     32'(ready), 32'd1);
                check("rw_read_data", 32'(read_data), 32'd0);
            end
        end
        check("rw_done_count", 32'(dones), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
